scalar_wb_arbiter: RTL and testbench
====================================

SCALAR_WB_ARBITER -- requirements
Module: scalar_wb_arbiter

Interface
REQ-001 The block SHALL have parameter LEN, default 32, meaning the scalar data width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low (rst==0 at a rising edge of clk resets the block).
REQ-004 The block SHALL have port rdy_in, input, 1 bit: global enable; when 0, no grant, no issue, and no state change.
REQ-005 The block SHALL have ports req_valid, input, 3 bits: one write-back request per source (bit 0 scalar ALU, bit 1 load unit, bit 2 vector-to-scalar unit).
REQ-006 The block SHALL have ports req_rd, input, 3x5 bits, and req_data, input, 3xLEN bits: per-source destination index and data.
REQ-007 The block SHALL have port req_grant, input-paired output, 3 bits: one-hot grant; source i's request is consumed in a cycle with req_grant[i]==1.
REQ-008 The block SHALL have ports issue_valid (input, 1), issue_rd (input, 5), issue_rs1/issue_rs2 (input, 5 each), and issue_use_rs1/issue_use_rs2 (input, 1 each): decode-stage issue request.
REQ-009 The block SHALL have port issue_stall, output, 1 bit: combinational hazard indication for the current issue request.
REQ-010 The block SHALL have ports wb_enabled (output, 1), wb_rf_signal (output, 2), wb_rd (output, 5), and wb_data (output, LEN): register-file write port drive.
REQ-011 The block SHALL have port pending_mask, output, 32 bits: the scoreboard contents.

Function
REQ-012 Requests SHALL be arbitrated round-robin: the search starts at the source after the last granted source, wrapping 2->0.
REQ-013 At most one req_grant bit SHALL be 1 per cycle; req_grant SHALL be 0 when rdy_in==0 or rst==0.
REQ-014 A granted request SHALL appear on wb_enabled=1, wb_rf_signal=SCALAR_RF_WRITE, wb_rd, and wb_data at the next rising edge (latency 1).
REQ-015 In a cycle with no grant, wb_enabled SHALL be 0 and wb_rf_signal SHALL be RF_NOP at the next edge; wb_rd and wb_data SHALL hold.
REQ-016 Requests with req_rd==0 SHALL be granted and consumed, but SHALL produce wb_enabled=0 (x0 is never written).
REQ-017 issue_stall SHALL equal (issue_use_rs1 & pending[rs1]) | (issue_use_rs2 & pending[rs2]) | pending[issue_rd] (covering RAW and WAW), gated by issue_valid.
REQ-018 An issue SHALL be accepted when issue_valid & !issue_stall & rdy_in; acceptance SHALL set pending[issue_rd] at the next edge unless issue_rd==0.
REQ-019 A grant SHALL clear pending[req_rd] of the granted source at the next edge.
REQ-020 If set and clear target the same index in one cycle, set SHALL win.
REQ-021 pending[0] SHALL always read 0.
REQ-022 Sources SHALL hold req_valid, req_rd, and req_data stable until granted; the block does not buffer ungranted requests.

Reset
REQ-023 On reset, pending_mask SHALL be 0, req_grant 0, wb_enabled 0, wb_rf_signal RF_NOP, wb_rd 0, wb_data 0, and the round-robin pointer SHALL be set so that source 0 is highest priority.
REQ-024 Reset asserted mid-operation SHALL discard all pending bits and any in-flight grant within that cycle; no write SHALL be emitted on the following cycle.

Configuration
REQ-025 With macro SCALAR_WB_BYPASS_EN defined, a pending bit cleared by the current cycle's grant SHALL NOT cause issue_stall in that same cycle (same-cycle release); the decode stage then reads the forwarded value from wb_data one cycle later.
REQ-026 Without SCALAR_WB_BYPASS_EN, issue_stall SHALL use the registered pending_mask only, so a release becomes visible one cycle after the grant.

Verification
REQ-027 Reset, then req_valid=3'b111 with rd=1,2,3 held -> grants in order 0,1,2 on consecutive cycles; wb_rd=1,2,3 each one cycle later.
REQ-028 Issue rd=5 accepted -> pending_mask=0x20; a later issue with rs1=5, use_rs1=1 -> issue_stall=1 until source 1 is granted with rd=5.
REQ-029 Accepted issue rd=0 and request rd=0 with data 0xDEAD -> pending_mask stays 0; grant given; wb_enabled stays 0.
REQ-030 Same cycle: issue rd=7 accepted and grant of rd=7 -> pending[7]=1 afterwards.
REQ-031 rdy_in=0 for 3 cycles with requests present -> no grants, outputs and pending_mask unchanged; rst=0 with pending_mask=0xFFFE -> all cleared next edge.
REQ-032 Bypass: pending[9]=1, grant clears rd=9 while issue has rs2=9 -> with SCALAR_WB_BYPASS_EN, issue_stall=0 in that cycle; without it, issue_stall=1 in that cycle and 0 in the next.

Source files
------------

// File: rtl/scalar_wb_arbiter.sv
// scalar_wb_arbiter: round-robin write-back arbiter with a register scoreboard; SCALAR_WB_BYPASS_EN enables same-cycle release.
module scalar_wb_arbiter #(
  parameter int LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy_in,
  input  logic [2:0]          req_valid,
  input  logic [2:0][4:0]     req_rd,
  input  logic [2:0][LEN-1:0] req_data,
  output logic [2:0]          req_grant,
  input  logic                issue_valid,
  input  logic [4:0]          issue_rd,
  input  logic [4:0]          issue_rs1,
  input  logic [4:0]          issue_rs2,
  input  logic                issue_use_rs1,
  input  logic                issue_use_rs2,
  output logic                issue_stall,
  output logic                wb_enabled,
  output logic [1:0]          wb_rf_signal,
  output logic [4:0]          wb_rd,
  output logic [LEN-1:0]      wb_data,
  output logic [31:0]         pending_mask
);
  localparam logic [1:0] RF_NOP = 2'b00;
  localparam logic [1:0] SCALAR_RF_WRITE = 2'b01;
  logic [1:0] last, c1, c2, sel;
  logic gnt, accept;
  logic [4:0] g_rd;
  logic [LEN-1:0] g_data;
  logic [31:0] clr, set, view;
  assign c1 = last == 2'd2 ? 2'd0 : last + 2'd1;
  assign c2 = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
  // search order c1, c2, last: the last winner ends up lowest priority
  always_comb begin
    sel = req_valid[c1] ? c1 : req_valid[c2] ? c2 : last;
    gnt = rst && rdy_in && |req_valid;
    req_grant = '0;
    req_grant[sel] = gnt;
  end
  assign g_rd = req_rd[sel];
  assign g_data = req_data[sel];
  assign clr = gnt ? 32'd1 << g_rd : '0;
`ifdef SCALAR_WB_BYPASS_EN
  assign view = pending_mask & ~clr;
`else
  assign view = pending_mask;
`endif
  assign issue_stall = issue_valid && ((issue_use_rs1 && view[issue_rs1]) ||
                       (issue_use_rs2 && view[issue_rs2]) || view[issue_rd]);
  assign accept = issue_valid && !issue_stall && rdy_in;
  assign set = accept && issue_rd != '0 ? 32'd1 << issue_rd : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_mask <= '0;
      last <= 2'd2;
      wb_enabled <= 1'b0;
      wb_rf_signal <= RF_NOP;
      wb_rd <= '0;
      wb_data <= '0;
    end else if (rdy_in) begin
      pending_mask <= ((pending_mask & ~clr) | set) & ~32'd1;
      wb_enabled <= gnt && g_rd != '0;
      wb_rf_signal <= gnt && g_rd != '0 ? SCALAR_RF_WRITE : RF_NOP;
      if (gnt) begin
        last <= sel;
        wb_rd <= g_rd;
        wb_data <= g_data;
      end
    end
  end
endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// tb_scalar_wb_arbiter: directed scenarios plus random traffic checked against a behavioural scoreboard model.
module tb_scalar_wb_arbiter;
  localparam logic [1:0] RF_NOP = 2'b00;
  localparam logic [1:0] SCALAR_RF_WRITE = 2'b01;
  logic clk = 1'b0, rst, rdy_in;
  logic [2:0] req_valid, req_grant;
  logic [2:0][4:0] req_rd;
  logic [2:0][31:0] req_data;
  logic issue_valid, issue_use_rs1, issue_use_rs2, issue_stall;
  logic [4:0] issue_rd, issue_rs1, issue_rs2, wb_rd;
  logic wb_enabled;
  logic [1:0] wb_rf_signal;
  logic [31:0] wb_data, pending_mask;
  int checks = 0, errors = 0;
  logic [31:0] m_pend;
  int m_last, m_gs;
  logic m_wen;
  logic [1:0] m_rf;
  logic [4:0] m_rd;
  logic [31:0] m_data;
  logic [2:0] hv;
  logic [4:0] hrd [3];
  logic [31:0] hdata [3];

  scalar_wb_arbiter #(.LEN(32)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .req_valid(req_valid), .req_rd(req_rd),
    .req_data(req_data), .req_grant(req_grant), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_stall(issue_stall), .wb_enabled(wb_enabled), .wb_rf_signal(wb_rf_signal),
    .wb_rd(wb_rd), .wb_data(wb_data), .pending_mask(pending_mask));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    req_valid = hv;
    for (int i = 0; i < 3; i++) begin
      req_rd[i] = hrd[i];
      req_data[i] = hdata[i];
    end
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2);
    issue_valid = v; issue_rd = rd; issue_rs1 = rs1; issue_use_rs1 = u1;
    issue_rs2 = rs2; issue_use_rs2 = u2;
  endtask

  // one clock: check combinational outputs before the edge, registered outputs after it
  task automatic cyc();
    logic [2:0] eg;
    logic es;
    logic [31:0] view;
    apply();
    @(negedge clk);
    m_gs = -1;
    eg = '0;
    if (rst && rdy_in)
      for (int k = 1; k <= 3; k++)
        if (m_gs < 0 && req_valid[(m_last + k) % 3]) m_gs = (m_last + k) % 3;
    if (m_gs >= 0) eg[m_gs] = 1'b1;
    view = m_pend;
`ifdef SCALAR_WB_BYPASS_EN
    if (m_gs >= 0) view[req_rd[m_gs]] = 1'b0;
`endif
    es = issue_valid && ((issue_use_rs1 && view[issue_rs1]) ||
         (issue_use_rs2 && view[issue_rs2]) || view[issue_rd]);
    check("req_grant", 64'(req_grant), 64'(eg));
    check("issue_stall", 64'(issue_stall), 64'(es));
    if (!rst) begin
      m_pend = '0; m_last = 2; m_wen = 0; m_rf = RF_NOP; m_rd = '0; m_data = '0;
    end else if (rdy_in) begin
      if (m_gs >= 0) begin
        m_pend[req_rd[m_gs]] = 1'b0;
        m_last = m_gs;
        m_rd = req_rd[m_gs];
        m_data = req_data[m_gs];
        m_wen = m_rd != 0;
        m_rf = m_wen ? SCALAR_RF_WRITE : RF_NOP;
      end else begin
        m_wen = 0;
        m_rf = RF_NOP;
      end
      if (issue_valid && !es && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      m_pend[0] = 1'b0;
    end
    @(posedge clk);
    #1;
    check("pending_mask", 64'(pending_mask), 64'(m_pend));
    check("wb_enabled", 64'(wb_enabled), 64'(m_wen));
    check("wb_rf_signal", 64'(wb_rf_signal), 64'(m_rf));
    check("wb_rd", 64'(wb_rd), 64'(m_rd));
    check("wb_data", 64'(wb_data), 64'(m_data));
    if (m_gs >= 0) hv[m_gs] = 1'b0;
  endtask

  task automatic put(input int s, input logic [4:0] rd, input logic [31:0] d);
    hv[s] = 1'b1; hrd[s] = rd; hdata[s] = d;
  endtask

  initial begin
    m_pend = '0; m_last = 2; m_wen = 0; m_rf = RF_NOP; m_rd = '0; m_data = '0;
    hv = '0;
    for (int i = 0; i < 3; i++) begin hrd[i] = '0; hdata[i] = '0; end
    rst = 1'b0; rdy_in = 1'b1;
    issue(0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    check("reset_pending", 64'(pending_mask), 64'h0);
    check("reset_wb_en", 64'(wb_enabled), 64'h0);
    rst = 1'b1;
    // three sources at once: grants 0,1,2 on consecutive cycles
    put(0, 1, 32'h11); put(1, 2, 32'h22); put(2, 3, 32'h33);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rr_order", 64'(m_gs), 64'(i));
      check("rr_wb_rd", 64'(wb_rd), 64'(i + 1));
    end
    cyc();
    // RAW hazard on x5 held until load unit writes x5
    issue(1, 5, 0, 0, 0, 0); cyc();
    check("pend_x5", 64'(pending_mask), 64'h20);
    issue(1, 6, 5, 1, 0, 0); cyc(); cyc();
    put(1, 5, 32'h5555); cyc(); cyc(); cyc();
    // x0 never marked pending, never written
    issue(1, 0, 0, 0, 0, 0); put(0, 0, 32'hDEAD); cyc();
    check("x0_no_write", 64'(wb_enabled), 64'h0);
    // same-cycle set and clear of x7: set wins
    issue(1, 7, 0, 0, 0, 0); put(2, 7, 32'h77); cyc();
    check("x7_set_wins", 64'(pending_mask[7]), 64'h1);
    issue(0, 0, 0, 0, 0, 0);
    // global stall freezes everything
    put(0, 8, 32'h88); put(1, 9, 32'h99); rdy_in = 1'b0;
    issue(1, 12, 0, 0, 0, 0);
    cyc(); cyc(); cyc();
    rdy_in = 1'b1; issue(0, 0, 0, 0, 0, 0); cyc(); cyc();
    for (int r = 1; r < 32; r++) begin issue(1, 5'(r), 0, 0, 0, 0); cyc(); end
    issue(0, 0, 0, 0, 0, 0);
    check("pend_full", 64'(pending_mask), 64'hFFFF_FFFE);
    put(0, 4, 32'h44); rst = 1'b0; cyc();
    check("rst_clears", 64'(pending_mask), 64'h0);
    rst = 1'b1; hv = '0; cyc();
    // release of x9 while a reader of x9 waits
    issue(1, 9, 0, 0, 0, 0); cyc();
    issue(1, 10, 0, 0, 9, 1); put(0, 9, 32'h9999); cyc();
`ifdef SCALAR_WB_BYPASS_EN
    check("bypass_release", 64'(pending_mask[10]), 64'h1);
`else
    check("no_bypass_hold", 64'(pending_mask[10]), 64'h0);
    cyc();
    check("no_bypass_next", 64'(pending_mask[10]), 64'h1);
`endif
    // random traffic with sources holding requests until granted
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom % 150) != 0;
      rdy_in = ($urandom % 8) != 0;
      for (int s = 0; s < 3; s++)
        if (!hv[s] && $urandom % 2 == 1) put(s, 5'($urandom % ((n % 3 == 0) ? 32 : 8)), $urandom);
      issue(1'($urandom), 5'($urandom % 8), 5'($urandom % 8), 1'($urandom),
            5'($urandom % 8), 1'($urandom));
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
